sseg_scan_driver: RTL and testbench

- Output-side counterpart to the board's switch/button-driven logic. Takes a 16-bit result value and drives the Basys3 4-digit multiplexed seven-segment display as 4 hex digits.
- Time-multiplexes the anodes with a prescaled scan counter.
- Double-buffers the value so a digit never changes mid-frame.
- Inserts a blanking guard at each digit change to suppress ghosting.

---
 rtl/sseg_scan_driver.sv | 125 ++++++++++++
 tb/tb_sseg_scan_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Scanning driver for a 4-digit multiplexed seven-segment display (hex digits, frame-buffered).
// Optional leading-zero suppression is enabled by defining SSEG_LZ_BLANK_EN.
module sseg_scan_driver #(
    parameter int DIGIT_TICKS = 100000,
    parameter int GUARD_TICKS = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);
    localparam int CW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [CW-1:0] LAST  = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] GUARD = CW'(GUARD_TICKS);

    logic          run;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   pend_val, disp_val;
    logic [3:0]    pend_dp, disp_dp, pend_blank, disp_blank;
    logic [3:0]    nib;
    logic [6:0]    seg_hex;
    logic [3:0]    lz;
    logic          last_tick, frame_end, dark;

    assign last_tick = (cnt == LAST);
    assign frame_end = run && last_tick && (idx == 2'd3);
    assign nib       = disp_val[{idx, 2'b00} +: 4];
    assign dark      = disp_blank[idx] | lz[idx];

`ifdef SSEG_LZ_BLANK_EN
    logic z3, z2, z1;
    assign z3 = (disp_val[15:12] == 4'h0);
    assign z2 = (disp_val[11:8]  == 4'h0);
    assign z1 = (disp_val[7:4]   == 4'h0);
    assign lz = {z3, z3 & z2, z3 & z2 & z1, 1'b0};
`else
    assign lz = 4'b0000;
`endif

    always_comb begin
        seg_hex = 7'b1111111;
        case (nib)
            4'h0: seg_hex = 7'b1000000;
            4'h1: seg_hex = 7'b1111001;
            4'h2: seg_hex = 7'b0100100;
            4'h3: seg_hex = 7'b0110000;
            4'h4: seg_hex = 7'b0011001;
            4'h5: seg_hex = 7'b0010010;
            4'h6: seg_hex = 7'b0000010;
            4'h7: seg_hex = 7'b1111000;
            4'h8: seg_hex = 7'b0000000;
            4'h9: seg_hex = 7'b0010000;
            4'hA: seg_hex = 7'b0001000;
            4'hB: seg_hex = 7'b0000011;
            4'hC: seg_hex = 7'b1000110;
            4'hD: seg_hex = 7'b0100001;
            4'hE: seg_hex = 7'b0000110;
            default: seg_hex = 7'b0001110;
        endcase
    end

    // run gates the first edge after reset so that edge lands on slot 0, cycle 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
            idx <= 2'd0;
        end else begin
            run <= 1'b1;
            if (run) begin
                if (last_tick) begin
                    cnt <= '0;
                    idx <= idx + 2'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // A load coinciding with the frame boundary bypasses pending straight to display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
        end else begin
            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
            end
            if (frame_end) begin
                disp_val   <= load ? value    : pend_val;
                disp_dp    <= load ? dp_in    : pend_dp;
                disp_blank <= load ? blank_in : pend_blank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else if (!run || cnt < GUARD) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= dark ? 7'b1111111 : seg_hex;
            dp  <= disp_blank[idx] | ~disp_dp[idx];
        end
    end
endmodule

// File: tb/tb_sseg_scan_driver.sv
// Randomized self-checking bench for sseg_scan_driver against a frame-level reference model.
module tb_sseg_scan_driver;
    localparam int DT = 4;
    localparam int GT = 1;

    logic        clk, rst_n, load;
    logic [15:0] value;
    logic [3:0]  dp_in, blank_in, an;
    logic [6:0]  seg;
    logic        dp;

    int ncmp = 0;
    int nfail = 0;
    int ecnt = 0;

    typedef struct { int e; logic [15:0] v; logic [3:0] d; logic [3:0] b; } load_t;
    typedef struct { logic [3:0] an; logic [6:0] seg; logic dp; } pins_t;
    load_t q[$];

    logic [6:0] hexlut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    sseg_scan_driver #(.DIGIT_TICKS(DT), .GUARD_TICKS(GT)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
        .blank_in(blank_in), .seg(seg), .dp(dp), .an(an));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pins after edge k (edges counted from reset release). Frame f's contents are the last
    // load sampled at or before the edge that starts frame f; frame 0 shows zeros.
    function automatic pins_t model(int k);
        pins_t p;
        int t, f, slot, ph;
        logic [15:0] v;
        logic [3:0] d, b;
        logic hide, lzd;
        p = '{4'hF, 7'h7F, 1'b1};
        if (k < 2) return p;
        t = k - 2;
        f = t / (4 * DT);
        slot = (t / DT) % 4;
        ph = t % DT;
        if (ph < GT) return p;
        v = 0; d = 0; b = 0;
        if (f >= 1)
            foreach (q[i]) if (q[i].e <= 4 * DT * f + 1) begin v = q[i].v; d = q[i].d; b = q[i].b; end
        p.an = ~(4'b0001 << slot);
        hide = b[slot];
`ifdef SSEG_LZ_BLANK_EN
        lzd = (slot > 0) && ((v >> (4 * slot)) == 0);
`else
        lzd = 1'b0;
`endif
        p.seg = (hide || lzd) ? 7'h7F : hexlut[(v >> (4 * slot)) & 16'hF];
        p.dp = hide ? 1'b1 : ~d[slot];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) ecnt++;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp_in = d; blank_in = b; load = 1'b1;
        tick();
        q.push_back('{ecnt, v, d, b});
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ncmp++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            nfail++; $display("FAIL reset_hold an/seg/dp=%b/%b/%b want 1111/1111111/1", an, seg, dp);
        end
        rst_n = 1'b1; ecnt = 0; q.delete();
        for (int i = 1; i <= 3; i++) begin
            tick();
            ncmp++;
            if (i < 3 && {an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
                nfail++; $display("FAIL reset_guard cyc%0d an/seg=%b/%b want 1111/1111111", i, an, seg);
            end else if (i == 3 && {an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
                nfail++; $display("FAIL reset_first an/seg/dp=%b/%b/%b want 1110/1000000/1", an, seg, dp);
            end
        end
    endtask

    task automatic test_scan();
        pins_t e;
        do_load(16'h12AF, 4'h0, 4'h0);
        repeat (3 * 4 * DT) begin
            tick(); e = model(ecnt); ncmp++;
            if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                nfail++; $display("FAIL scan k=%0d got %b/%b/%b want %b/%b/%b", ecnt, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_tear();
        pins_t e;
        int n;
        do_load(16'h0000, 4'h0, 4'h0);
        repeat (4 * DT) tick();
        n = 0;
        while (!(((ecnt - 2) / DT) % 4 == 2 && (ecnt - 2) % DT >= GT) && n < 8 * DT) begin tick(); n++; end
        ncmp++;
        if (n >= 8 * DT) begin nfail++; $display("FAIL tear_wait timeout got %0d want <%0d", n, 8 * DT); end
        do_load(16'h8888, 4'h0, 4'h0);
        repeat (2 * 4 * DT) begin
            tick(); e = model(ecnt); ncmp++;
            if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                nfail++; $display("FAIL tear k=%0d got %b/%b/%b want %b/%b/%b", ecnt, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
        n = 0;
        while (ecnt % (4 * DT) != 0 && n < 8 * DT) begin tick(); n++; end
        do_load(16'($urandom), 4'($urandom), 4'h0);
        repeat (2 * 4 * DT) begin
            tick(); e = model(ecnt); ncmp++;
            if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                nfail++; $display("FAIL boundary_load k=%0d got %b/%b/%b want %b/%b/%b", ecnt, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_dp_blank();
        pins_t e;
        do_load(16'h4321, 4'b0101, 4'b1000);
        repeat (3 * 4 * DT) begin
            tick(); e = model(ecnt); ncmp++;
            if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                nfail++; $display("FAIL dp_blank k=%0d got %b/%b/%b want %b/%b/%b", ecnt, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_random();
        pins_t e;
        repeat (400) begin
            load = ($urandom_range(0, 7) == 0);
            value = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom & $urandom);
            tick();
            if (load) q.push_back('{ecnt, value, dp_in, blank_in});
            load = 1'b0;
            e = model(ecnt); ncmp++;
            if ({an, seg, dp} !== {e.an, e.seg, e.dp} || $countones(~an) > 1) begin
                nfail++; $display("FAIL random k=%0d got %b/%b/%b want %b/%b/%b", ecnt, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_midreset();
        pins_t e;
        int n;
        do_load(16'($urandom) | 16'h0100, 4'h0, 4'h0);
        n = 0;
        while (!(ecnt > 4 * DT + 2 && ((ecnt - 2) / DT) % 4 == 2 && (ecnt - 2) % DT >= GT) && n < 12 * DT) begin
            tick(); n++;
        end
        rst_n = 1'b0;
        #1;
        ncmp++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            nfail++; $display("FAIL midreset_dark got %b/%b/%b want 1111/1111111/1", an, seg, dp);
        end
        load = 1'b1; value = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        load = 1'b0;
        rst_n = 1'b1; ecnt = 0; q.delete();
        repeat (2 * 4 * DT) begin
            tick(); e = model(ecnt); ncmp++;
            if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                nfail++; $display("FAIL midreset k=%0d got %b/%b/%b want %b/%b/%b", ecnt, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_lz();
        pins_t e;
        do_load(16'h0050, 4'h0, 4'h0);
        repeat (2 * 4 * DT) begin
            tick(); e = model(ecnt); ncmp++;
            if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                nfail++; $display("FAIL lz_0050 k=%0d got %b/%b/%b want %b/%b/%b", ecnt, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
        do_load(16'h0000, 4'b0100, 4'h0);
        repeat (2 * 4 * DT) begin
            tick(); e = model(ecnt); ncmp++;
            if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                nfail++; $display("FAIL lz_0000 k=%0d got %b/%b/%b want %b/%b/%b", ecnt, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;
        #2;
        test_reset();
        test_scan();
        test_tear();
        test_dp_blank();
        test_random();
        test_midreset();
        test_lz();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
